// File: rtl/data_mem_lsu_pkg.sv
// mem_lsu_pkg: size encodings, FSM states and lane helpers shared by the data memory LSU.
package mem_lsu_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic [1:0] {ST_RST, ST_CLEAR, ST_RUN} state_t;

    // 2^size consecutive lanes starting at off; callers truncate to their lane count.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
        logic [8:0] m;
        m = (9'd1 << (4'd1 << size)) - 9'd1;
        return m[7:0] << off;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off, input logic wide);
        logic [3:0] a;
        a = (4'd1 << size) - 4'd1;
        return (size == SZ_DWORD && !wide) || ((off & a[2:0]) != 3'd0);
    endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// data_mem_lsu_if: load/store request and response signals of the MEM-stage data memory.
interface data_mem_lsu_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        rd_size;
    logic              rd_signed;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        wr_size;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              misaligned;
    logic [ADDR_W-1:0] err_addr;

    modport master (
        output rd_en, rd_addr, rd_size, rd_signed, wr_en, wr_addr, wr_size, wr_data,
        input  rd_data, rd_valid, busy, misaligned, err_addr
    );

    modport slave (
        input  rd_en, rd_addr, rd_size, rd_signed, wr_en, wr_addr, wr_size, wr_data,
        output rd_data, rd_valid, busy, misaligned, err_addr
    );
endinterface

// File: rtl/data_mem_lsu_ram.sv
// mem_lsu_ram: DEPTH x DATA_W array with byte-enabled write port and registered read port.
module mem_lsu_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    localparam int NB    = DATA_W / 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [NB-1:0]     i_be,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Read returns the pre-write contents; same-word forwarding is handled by the caller.
    always_ff @(posedge clk) begin
        if (i_we)
            for (int i = 0; i < NB; i++)
                if (i_be[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: byte-addressed data memory with sized/extended loads, masked stores,
// write-first collision forwarding, misalignment trapping and post-reset clearing.
module data_mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 10,
    parameter bit CLEAR_ON_RESET = 1
) (
    input logic           clk,
    input logic           reset,
    data_mem_lsu_if.slave bus
);
    localparam int NB     = DATA_W / 8;
    localparam int OFF_W  = $clog2(NB);
    localparam int WORD_W = ADDR_W - OFF_W;
    localparam int DEPTH  = 1 << WORD_W;

    state_t              r_state, w_next;
    logic [WORD_W-1:0]   r_clr;
    logic                r_rd_valid, r_rd_mis, r_rd_signed, r_mis;
    logic [OFF_W-1:0]    r_rd_off;
    logic [1:0]          r_rd_size;
    logic [NB-1:0]       r_fwd_be;
    logic [DATA_W-1:0]   r_fwd_data;
    logic [ADDR_W-1:0]   r_err_addr;

    logic                w_run, w_clearing;
    logic [OFF_W-1:0]    w_rd_off, w_wr_off;
    logic [WORD_W-1:0]   w_rd_word, w_wr_word;
    logic                w_rd_ok, w_rd_bad, w_wr_ok, w_wr_bad, w_collide;
    logic [NB-1:0]       w_wr_be, w_ld_be;
    logic [DATA_W-1:0]   w_wr_sh, w_q, w_fwd_bm, w_ld_bm, w_word, w_sh, w_ext;
    logic                w_sbit;

    always_ff @(posedge clk) begin
        r_state <= reset ? ST_RST : w_next;
        r_clr   <= (reset || r_state != ST_CLEAR) ? '0 : r_clr + 1'b1;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == ST_RST) w_next = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
        else if (r_state == ST_CLEAR && r_clr == '1) w_next = ST_RUN;
    end

    assign w_run      = r_state == ST_RUN;
    assign w_clearing = r_state == ST_CLEAR;

    assign w_rd_off  = bus.rd_addr[OFF_W-1:0];
    assign w_wr_off  = bus.wr_addr[OFF_W-1:0];
    assign w_rd_word = bus.rd_addr[ADDR_W-1:OFF_W];
    assign w_wr_word = bus.wr_addr[ADDR_W-1:OFF_W];

    assign w_rd_bad  = w_run && bus.rd_en && is_misaligned(bus.rd_size, 3'(w_rd_off), DATA_W == 64);
    assign w_wr_bad  = w_run && bus.wr_en && is_misaligned(bus.wr_size, 3'(w_wr_off), DATA_W == 64);
    assign w_rd_ok   = w_run && bus.rd_en && !w_rd_bad;
    assign w_wr_ok   = w_run && bus.wr_en && !w_wr_bad;
    assign w_collide = w_rd_ok && w_wr_ok && w_rd_word == w_wr_word;

    assign w_wr_be = NB'(lane_mask(bus.wr_size, 3'(w_wr_off)));
    assign w_wr_sh = bus.wr_data << {w_wr_off, 3'b000};

    mem_lsu_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .i_we    (w_clearing || w_wr_ok),
        .i_be    (w_clearing ? '1 : w_wr_be),
        .i_waddr (w_clearing ? r_clr : w_wr_word),
        .i_wdata (w_clearing ? '0 : w_wr_sh),
        .i_raddr (w_rd_word),
        .o_rdata (w_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid  <= 1'b0;
            r_rd_mis    <= 1'b0;
            r_rd_signed <= 1'b0;
            r_rd_off    <= '0;
            r_rd_size   <= SZ_BYTE;
            r_fwd_be    <= '0;
            r_fwd_data  <= '0;
            r_mis       <= 1'b0;
            r_err_addr  <= '0;
        end else begin
            r_rd_valid  <= w_rd_ok || w_rd_bad;
            r_rd_mis    <= w_rd_bad;
            r_rd_signed <= bus.rd_signed;
            r_rd_off    <= w_rd_off;
            r_rd_size   <= bus.rd_size;
            r_fwd_be    <= w_collide ? w_wr_be : '0;
            r_fwd_data  <= w_wr_sh;
            r_mis       <= w_rd_bad || w_wr_bad;
            r_err_addr  <= w_rd_bad ? bus.rd_addr : w_wr_bad ? bus.wr_addr : r_err_addr;
        end
    end

    assign w_ld_be = NB'(lane_mask(r_rd_size, 3'd0));
    for (genvar g = 0; g < NB; g++) begin : g_lane
        assign w_fwd_bm[8*g +: 8] = {8{r_fwd_be[g]}};
        assign w_ld_bm[8*g +: 8]  = {8{w_ld_be[g]}};
    end

    // Written lanes win over the array's pre-write word on a same-cycle collision.
    assign w_word = (w_q & ~w_fwd_bm) | (r_fwd_data & w_fwd_bm);
    assign w_sh   = w_word >> {r_rd_off, 3'b000};
    assign w_sbit = r_rd_size == SZ_BYTE ? w_sh[7] : r_rd_size == SZ_HALF ? w_sh[15] : w_sh[31];
    assign w_ext  = (w_sh & w_ld_bm) | ((r_rd_signed && w_sbit) ? ~w_ld_bm : '0);

    assign bus.rd_data    = (r_rd_valid && !r_rd_mis) ? w_ext : '0;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.busy       = w_clearing;
    assign bus.misaligned = r_mis;
    assign bus.err_addr   = r_err_addr;
endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: directed checks of clearing, sized loads/stores, forwarding and traps.
module tb_data_mem_lsu;
    import mem_lsu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tot = 0;
    int   n_bad = 0;
    int   c32, c64;
    bit   saw_v;

    always #5 clk = ~clk;

    data_mem_lsu_if #(.DATA_W(32), .ADDR_W(10)) b32();
    data_mem_lsu_if #(.DATA_W(64), .ADDR_W(10)) b64();

    data_mem_lsu #(.DATA_W(32), .ADDR_W(10), .CLEAR_ON_RESET(1)) dut32 (.clk(clk), .reset(reset), .bus(b32));
    data_mem_lsu #(.DATA_W(64), .ADDR_W(10), .CLEAR_ON_RESET(1)) dut64 (.clk(clk), .reset(reset), .bus(b64));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        b32.rd_en = 0; b32.rd_addr = '0; b32.rd_size = SZ_WORD; b32.rd_signed = 0;
        b32.wr_en = 0; b32.wr_addr = '0; b32.wr_size = SZ_WORD; b32.wr_data = '0;
        b64.rd_en = 0; b64.rd_addr = '0; b64.rd_size = SZ_DWORD; b64.rd_signed = 0;
        b64.wr_en = 0; b64.wr_addr = '0; b64.wr_size = SZ_DWORD; b64.wr_data = '0;
    endtask

    task automatic st(input logic [9:0] a, input logic [1:0] sz, input logic [31:0] d);
        b32.wr_en = 1; b32.wr_addr = a; b32.wr_size = sz; b32.wr_data = d;
        tick;
        b32.wr_en = 0;
    endtask

    task automatic ld(input logic [9:0] a, input logic [1:0] sz, input logic sg);
        b32.rd_en = 1; b32.rd_addr = a; b32.rd_size = sz; b32.rd_signed = sg;
        tick;
        b32.rd_en = 0;
    endtask

    task automatic ld_chk(input string tag, input logic [9:0] a, input logic [1:0] sz,
                          input logic sg, input logic [31:0] exp);
        ld(a, sz, sg);
        chk({tag, "_valid"}, b32.rd_valid, 1);
        chk(tag, b32.rd_data, exp);
    endtask

    task automatic ld64_chk(input string tag, input logic [9:0] a, input logic [1:0] sz,
                            input logic sg, input logic [63:0] exp);
        b64.rd_en = 1; b64.rd_addr = a; b64.rd_size = sz; b64.rd_signed = sg;
        tick;
        b64.rd_en = 0;
        chk(tag, b64.rd_data, exp);
    endtask

    // Counts busy samples of both instances; bounded so a stuck busy still reaches the summary.
    task automatic run_clear(output int n32, output int n64, output bit v);
        n32 = 0; n64 = 0; v = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!b32.busy && !b64.busy) break;
            n32 += int'(b32.busy);
            n64 += int'(b64.busy);
            v |= b32.rd_valid;
            tick;
        end
        v |= b32.rd_valid;
    endtask

    initial begin
        idle;
        repeat (3) tick;
        chk("rst_rd_valid", b32.rd_valid, 0);
        chk("rst_rd_data", b32.rd_data, 0);
        chk("rst_busy", b32.busy, 0);
        chk("rst_misaligned", b32.misaligned, 0);
        chk("rst_err_addr", b32.err_addr, 0);

        reset = 0;
        b32.rd_en = 1;
        tick;
        run_clear(c32, c64, saw_v);
        b32.rd_en = 0;
        chk("busy32_cycles", c32, 256);
        chk("busy64_cycles", c64, 128);
        chk("busy_rd_dropped", saw_v, 0);
        ld_chk("clr_lw_3fc", 10'h3FC, SZ_WORD, 0, 32'h0);

        st(10'h010, SZ_WORD, 32'h8899AABB);
        ld_chk("lb_s_011", 10'h011, SZ_BYTE, 1, 32'hFFFFFFAA);
        ld_chk("lbu_011", 10'h011, SZ_BYTE, 0, 32'h000000AA);
        ld_chk("lh_s_012", 10'h012, SZ_HALF, 1, 32'hFFFF8899);
        ld_chk("lhu_010", 10'h010, SZ_HALF, 0, 32'h0000AABB);
        ld_chk("lw_010", 10'h010, SZ_WORD, 1, 32'h8899AABB);

        st(10'h013, SZ_BYTE, 32'hFFFFFF5A);
        ld_chk("lw_after_sb", 10'h010, SZ_WORD, 0, 32'h5A99AABB);

        st(10'h020, SZ_WORD, 32'hDEADBEEF);
        b32.wr_en = 1; b32.wr_addr = 10'h020; b32.wr_size = SZ_HALF; b32.wr_data = 32'hFFFF1234;
        ld_chk("collide_fwd", 10'h020, SZ_WORD, 0, 32'hDEAD1234);
        b32.wr_en = 0;
        ld_chk("collide_commit", 10'h020, SZ_WORD, 0, 32'hDEAD1234);

        b32.rd_en = 1; b32.rd_addr = 10'h010; b32.rd_size = SZ_WORD; b32.rd_signed = 0;
        tick;
        chk("b2b_first", b32.rd_data, 32'h5A99AABB);
        b32.rd_addr = 10'h020;
        tick;
        chk("b2b_second", b32.rd_data, 32'hDEAD1234);
        b32.rd_en = 0;
        tick;
        chk("rd_valid_pulse", b32.rd_valid, 0);

        st(10'h022, SZ_WORD, 32'hCAFEF00D);
        chk("sw_mis_flag", b32.misaligned, 1);
        chk("sw_mis_addr", b32.err_addr, 10'h022);
        tick;
        chk("mis_pulse_end", b32.misaligned, 0);
        ld_chk("sw_mis_no_write", 10'h020, SZ_WORD, 0, 32'hDEAD1234);
        chk("err_addr_hold", b32.err_addr, 10'h022);

        ld_chk("lh_mis_data", 10'h021, SZ_HALF, 1, 32'h0);
        chk("lh_mis_flag", b32.misaligned, 1);
        chk("lh_mis_addr", b32.err_addr, 10'h021);

        b32.wr_en = 1; b32.wr_addr = 10'h042; b32.wr_size = SZ_WORD; b32.wr_data = 32'h1;
        ld(10'h031, SZ_HALF, 0);
        b32.wr_en = 0;
        chk("both_mis_addr", b32.err_addr, 10'h031);
        chk("both_mis_flag", b32.misaligned, 1);

        ld_chk("ld_on_32", 10'h000, SZ_DWORD, 0, 32'h0);
        chk("ld_on_32_flag", b32.misaligned, 1);

        b64.wr_en = 1; b64.wr_addr = 10'h008; b64.wr_size = SZ_DWORD; b64.wr_data = 64'h0123456789ABCDEF;
        tick;
        b64.wr_en = 0;
        ld64_chk("sd_ld_008", 10'h008, SZ_DWORD, 1, 64'h0123456789ABCDEF);
        ld64_chk("lw_s_00c_64", 10'h00C, SZ_WORD, 1, 64'h0000000001234567);
        ld64_chk("lw_s_008_64", 10'h008, SZ_WORD, 1, 64'hFFFFFFFF89ABCDEF);
        ld64_chk("lb_s_008_64", 10'h008, SZ_BYTE, 1, 64'hFFFFFFFFFFFFFFEF);
        ld64_chk("ld_mis_64", 10'h00C, SZ_DWORD, 0, 64'h0);
        chk("ld_mis_64_addr", b64.err_addr, 10'h00C);

        reset = 1;
        repeat (2) tick;
        reset = 0;
        tick;
        repeat (100) tick;
        chk("busy_mid_clear", b32.busy, 1);
        reset = 1;
        tick;
        chk("busy_in_reset", b32.busy, 0);
        reset = 0;
        tick;
        run_clear(c32, c64, saw_v);
        chk("restart_busy32", c32, 256);
        chk("restart_busy64", c64, 128);
        ld_chk("recleared_010", 10'h010, SZ_WORD, 0, 32'h0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Parametrised data memory with load/store-unit front end for the MIPS datapath, replacing the fixed 256×32 word memory. It takes byte addresses and supports byte/half/word (and dword when 64-bit) accesses with byte-lane write masks and sign/zero-extended loads. It also provides registered single-cycle reads, write-first forwarding on same-word collisions, misalignment trapping and an optional post-reset clear sequencer. It sits in the MEM stage between the ALU result/store-data path and the writeback mux.

## Interface
- DATA_W, 32, word width; legal values 32 or 64
- ADDR_W, 10, byte-address width; DEPTH = 2^(ADDR_W − log2(DATA_W/8)) words
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = contents undefined/retained
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- rd_en  in  1  load request
- rd_addr  in  ADDR_W  load byte address
- rd_size  in  2  0 byte, 1 half, 2 word, 3 dword
- rd_signed  in  1  1 = sign-extend, 0 = zero-extend
- rd_data  out  DATA_W  right-justified, extended load result
- rd_valid  out  1  one-cycle pulse: rd_data valid
- wr_en  in  1  store request
- wr_addr  in  ADDR_W  store byte address
- wr_size  in  2  encoding as rd_size
- wr_data  in  DATA_W  store data, right-justified
- busy  out  1  clear in progress; requests dropped
- misaligned  out  1  one-cycle error pulse
- err_addr  out  ADDR_W  address of the last misaligned access

## Operation
- FSM: RST (reset high) → CLEAR (CLEAR_ON_RESET=1) or RUN; CLEAR → RUN after DEPTH cycles. RST is re-entered from any state whenever reset is high.
- CLEAR: a counter writes 0 to word 0..DEPTH−1, one word per cycle. busy=1. rd_en/wr_en are ignored with no rd_valid and no error. Reset during CLEAR restarts the counter at 0.
- Lane mapping is little-endian: offset o = addr[log2(DATA_W/8)−1:0] selects byte lane bits [8o+7:8o]. Word index = upper address bits.
- Store mask: 2^size consecutive lanes starting at o. Low 2^size bytes of wr_data are placed into those lanes. Other lanes are unchanged.
- Load: extract 2^size bytes from lane o, right-justify, then extend to DATA_W per rd_signed. Size equal to the full width ignores rd_signed.
- Misaligned: o not a multiple of 2^size, or size=3 with DATA_W=32.
  - Store: suppressed.
  - Load: rd_valid=1, rd_data=0.
  - misaligned pulses and err_addr captures the address. If both ports fault in the same cycle, err_addr takes rd_addr.
- Collision (rd_en and wr_en to the same word in one cycle, both aligned): the load returns merged data. Written lanes come from wr_data; other lanes come from the array (write-first).

## Timing
- Reset values: rd_data=0, rd_valid=0, busy=0 while reset high, misaligned=0, err_addr=0.
- busy rises the cycle after reset falls (CLEAR_ON_RESET=1). It stays high exactly DEPTH cycles.
- Load latency 1: rd_en sampled at edge k → rd_data/rd_valid valid after edge k, for one cycle. Back-to-back loads give one result per cycle.
- Store is committed at the sampling edge. A load at edge k+1 sees it; a load at edge k sees it via forwarding.
- misaligned and err_addr update one edge after the faulting request; misaligned holds for one cycle.
- Fully pipelined: no stalls in RUN.

## Structure
- Package mem_lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DWORD
  - FSM state enum
  - function for the lane-mask from size and offset
- Sub-module mem_lsu_ram: one write port with per-byte enable and one synchronous read port, DEPTH×DATA_W. Collision forwarding stays in the top level.

## Test plan
- Reset for 3 cycles, then release, DEPTH=256 → busy high exactly 256 cycles. Reads during busy give no rd_valid. Afterwards, a read of addr 0x3FC gives rd_data=0.
- SW 0x8899AABB @0x010. Then LB signed @0x011 → 0xFFFFFFAA. LBU @0x011 → 0x000000AA. LH signed @0x012 → 0xFFFF8899. LW @0x010 → 0x8899AABB.
- SB 0x5A @0x013 over the prior word → LW @0x010 = 0x5A99AABB.
- Same-cycle SH 0x1234 @0x020 and LW @0x020 (old word 0xDEADBEEF) → rd_data 0xDEAD1234 at the next edge.
- SW @0x022 → no write (LW @0x020 unchanged), misaligned=1 for one cycle, err_addr=0x022. LH @0x021 → rd_valid=1, rd_data=0, err_addr=0x021.
- Assert reset at clear count 100, release → busy high for a full 256 cycles again. DATA_W=64: SD/LD @0x008 round-trips 0x0123456789ABCDEF.
